// File: rtl/iq_demod_pkg.sv
// Shared types, default widths and the pair-select helper for the iq_demod
// datapath (sample buffer, pair sequencer, correlator).
package iq_demod_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEQ,
    ST_DIR
  } seq_state_t;

  // Defaults shared with the I/Q sample buffer.
  localparam int DEMOD_W      = 5;
  localparam int DEMOD_NPAIRS = 5;

  // Upper bounds that pair_sel accepts: W <= 16, NPAIRS <= 16.
  localparam int PAIR_MAX_W = 32;
  localparam int BANK_MAX_W = 512;

  // Returns pair idx of a bank of npairs pairs, each sample w bits wide.
  // Sample 2*idx lands in the low half of the result. Out-of-range index gives zero.
  function automatic logic [PAIR_MAX_W-1:0] pair_sel(
    input logic [BANK_MAX_W-1:0] bank,
    input int unsigned           idx,
    input int unsigned           w,
    input int unsigned           npairs
  );
    logic [PAIR_MAX_W-1:0] mask;
    mask = {PAIR_MAX_W{1'b1}} >> (PAIR_MAX_W - 2 * w);
    if (idx >= npairs) begin
      return '0;
    end
    return PAIR_MAX_W'(bank >> (idx * 2 * w)) & mask;
  endfunction

endpackage

// File: rtl/iq_pair_sequencer.sv
// Latches a bank of I/Q sample pairs and either streams them in index order
// (valid/ready) or presents a selected pair every cycle, all outputs registered.
module iq_pair_sequencer
  import iq_demod_pkg::*;
#(
  parameter  int W      = DEMOD_W,
  parameter  int NPAIRS = DEMOD_NPAIRS,
  localparam int SEL_W  = $clog2(NPAIRS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [2*NPAIRS*W-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [W-1:0]          out1,
  output logic [W-1:0]          out2,
  output logic [SEL_W-1:0]      out_idx,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int               PAIR_W   = 2 * W;
  localparam int               BANK_W   = 2 * NPAIRS * W;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NPAIRS - 1);

  seq_state_t         state_q, state_d;
  logic [BANK_W-1:0]  bank_q, bank_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [W-1:0]       out1_q, out1_d;
  logic [W-1:0]       out2_q, out2_d;
  logic [SEL_W-1:0]   out_idx_q, out_idx_d;
  logic               out_last_q, out_last_d;
  logic               out_valid_q, out_valid_d;

  logic               take_bank;
  logic [SEL_W-1:0]   nxt_idx;

  function automatic logic [PAIR_W-1:0] pick(
    input logic [BANK_W-1:0] bank,
    input logic [SEL_W-1:0]  i
  );
    return PAIR_W'(pair_sel(BANK_MAX_W'(bank), 32'(i), W, NPAIRS));
  endfunction

  // Only the last-pair handshake in SEQ opens the input, so a queued bank
  // follows the final pair with no bubble.
  assign in_ready = (state_q == ST_SEQ) ? (out_valid_q && out_ready && out_last_q) : 1'b1;
  assign nxt_idx  = idx_q + 1'b1;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers latches.
    state_d     = state_q;
    bank_d      = bank_q;
    idx_d       = idx_q;
    out1_d      = out1_q;
    out2_d      = out2_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    take_bank   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        {out2_d, out1_d} = '0;
        out_idx_d        = '0;
        out_last_d       = 1'b0;
        out_valid_d      = 1'b0;
        take_bank        = in_valid;
      end

      ST_SEQ: begin
        if (out_valid_q && out_ready) begin
          if (!out_last_q) begin
            idx_d            = nxt_idx;
            {out2_d, out1_d} = pick(bank_q, nxt_idx);
            out_idx_d        = nxt_idx;
            out_last_d       = (nxt_idx == LAST_IDX);
          end else begin
            state_d          = ST_IDLE;
            {out2_d, out1_d} = '0;
            out_idx_d        = '0;
            out_last_d       = 1'b0;
            out_valid_d      = 1'b0;
            take_bank        = in_valid;
          end
        end
      end

      ST_DIR: begin
        // Selection reads the bank held this cycle; a concurrent load lands next cycle.
        {out2_d, out1_d} = pick(bank_q, sel);
        out_idx_d        = sel;
        out_last_d       = 1'b0;
        out_valid_d      = (32'(sel) < NPAIRS);
        if (in_valid) begin
          bank_d = in_data;
        end
        if (!mode) begin
          state_d          = ST_IDLE;
          {out2_d, out1_d} = '0;
          out_idx_d        = '0;
          out_valid_d      = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (take_bank) begin
      bank_d = in_data;
      idx_d  = '0;
      if (!mode) begin
        state_d          = ST_SEQ;
        {out2_d, out1_d} = pick(in_data, '0);
        out_idx_d        = '0;
        out_last_d       = 1'b0;
        out_valid_d      = 1'b1;
      end else begin
        state_d = ST_DIR;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bank_q      <= '0;
      idx_q       <= '0;
      out1_q      <= '0;
      out2_q      <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      idx_q       <= idx_d;
      out1_q      <= out1_d;
      out2_q      <= out2_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out1      = out1_q;
  assign out2      = out2_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_iq_pair_sequencer.sv
// Self-checking bench for iq_pair_sequencer: directed sequences, a direct-mode
// vector table, a small NPAIRS=3/W=8 instance, and a randomized scoreboard run.
module tb_iq_pair_sequencer;

  localparam int W   = 5;
  localparam int NP  = 5;
  localparam int SW  = 3;
  localparam int BW  = 2 * NP * W;
  localparam int W2  = 8;
  localparam int NP2 = 3;
  localparam int SW2 = 2;
  localparam int BW2 = 2 * NP2 * W2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance (defaults)
  logic          mode, in_valid, in_ready, out_last, out_valid, out_ready, busy;
  logic [SW-1:0] sel, out_idx;
  logic [BW-1:0] in_data;
  logic [W-1:0]  out1, out2;

  // Small instance
  logic           mode2, in_valid2, in_ready2, out_last2, out_valid2, out_ready2, busy2;
  logic [SW2-1:0] sel2, out_idx2;
  logic [BW2-1:0] in_data2;
  logic [W2-1:0]  out1_2, out2_2;

  iq_pair_sequencer #(.W(W), .NPAIRS(NP)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out1(out1), .out2(out2),
    .out_idx(out_idx), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  iq_pair_sequencer #(.W(W2), .NPAIRS(NP2)) dut2 (
    .clk(clk), .rst(rst), .mode(mode2), .sel(sel2), .in_data(in_data2),
    .in_valid(in_valid2), .in_ready(in_ready2), .out1(out1_2), .out2(out2_2),
    .out_idx(out_idx2), .out_last(out_last2), .out_valid(out_valid2),
    .out_ready(out_ready2), .busy(busy2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Bank whose sample k equals base+k, so pair p is (base+2p, base+2p+1).
  function automatic logic [BW-1:0] mk_bank(input int base);
    logic [BW-1:0] b;
    b = '0;
    for (int k = 0; k < 2 * NP; k++) b[k*W +: W] = W'(base + k);
    return b;
  endfunction

  task automatic expect_pair(input string tag, input int p, input int base);
    check({tag, "_valid"}, 32'(out_valid), 1);
    check({tag, "_out1"},  32'(out1), 32'(base + 2 * p));
    check({tag, "_out2"},  32'(out2), 32'(base + 2 * p + 1));
    check({tag, "_idx"},   32'(out_idx), 32'(p));
    check({tag, "_last"},  32'(out_last), 32'(p == NP - 1));
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_rdy"},   32'(in_ready), 1);
  endtask

  typedef struct {
    logic [SW-1:0] sel;
    logic [W-1:0]  e1;
    logic [W-1:0]  e2;
    logic          ev;
  } dir_vec_t;

  typedef struct {
    int a;
    int b;
    int idx;
    bit last;
  } pair_t;

  dir_vec_t dir_tbl[7];
  pair_t    exp_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int     rdy_pat[7];
    int     p_pat[7];
    logic   [BW-1:0] rnd;
    bit     exp_valid, exp_rdy;
    pair_t  pr;

    dir_tbl[0] = '{3'd2, 5'd5,  5'd6,  1'b1};
    dir_tbl[1] = '{3'd4, 5'd9,  5'd10, 1'b1};
    dir_tbl[2] = '{3'd5, 5'd0,  5'd0,  1'b0};
    dir_tbl[3] = '{3'd0, 5'd1,  5'd2,  1'b1};
    dir_tbl[4] = '{3'd7, 5'd0,  5'd0,  1'b0};
    dir_tbl[5] = '{3'd3, 5'd7,  5'd8,  1'b1};
    dir_tbl[6] = '{3'd1, 5'd3,  5'd4,  1'b1};
    rdy_pat = '{1, 0, 0, 1, 1, 1, 1};
    p_pat   = '{0, 1, 1, 1, 2, 3, 4};

    rst = 1'b1; mode = 1'b0; sel = '0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    mode2 = 1'b0; sel2 = '0; in_data2 = '0; in_valid2 = 1'b0; out_ready2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    // Reset state
    check("rst_out1", 32'(out1), 0);
    check("rst_out2", 32'(out2), 0);
    check("rst_idx",  32'(out_idx), 0);
    check("rst_last", 32'(out_last), 0);
    expect_idle("rst");
    check("rst2_valid", 32'(out_valid2), 0);
    check("rst2_rdy",   32'(in_ready2), 1);

    // Basic sequence, downstream always ready
    @(negedge clk);
    in_data = mk_bank(1); mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1 check("t1_load_rdy", 32'(in_ready), 1);
    for (int p = 0; p < NP; p++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      expect_pair("t1", p, 1);
      check("t1_rdy",  32'(in_ready), 32'(p == NP - 1));
      check("t1_busy", 32'(busy), 1);
    end
    @(negedge clk);
    #1 expect_idle("t1_end");

    // Stalls: pair 1 held for two cycles; mode wiggles are ignored mid-sequence
    @(negedge clk);
    in_data = mk_bank(1); in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = rdy_pat[k][0];
      mode      = k[0];
      #1;
      expect_pair("t2", p_pat[k], 1);
      check("t2_rdy", 32'(in_ready), 32'(p_pat[k] == NP - 1 && rdy_pat[k] == 1));
    end
    @(negedge clk);
    mode = 1'b0;
    #1 expect_idle("t2_end");

    // Back-to-back banks with in_valid held
    @(negedge clk);
    in_data = mk_bank(1); in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 2 * NP; k++) begin
      @(negedge clk);
      in_data  = mk_bank(11);
      in_valid = (k < NP);
      #1;
      if (k < NP) expect_pair("t3a", k, 1);
      else        expect_pair("t3b", k - NP, 11);
    end
    @(negedge clk);
    #1 expect_idle("t3_end");

    // Reset mid-sequence at pair 2, then a fresh load restarts at pair 0
    @(negedge clk);
    in_data = mk_bank(1); in_valid = 1'b1;
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1 expect_pair("t4", p, 1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    expect_idle("t4_rst");
    check("t4_rst_out1", 32'(out1), 0);
    check("t4_rst_out2", 32'(out2), 0);
    check("t4_rst_idx",  32'(out_idx), 0);
    check("t4_rst_last", 32'(out_last), 0);
    in_data = mk_bank(11); in_valid = 1'b1;
    for (int p = 0; p < NP; p++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1 expect_pair("t4r", p, 11);
    end
    @(negedge clk);
    #1 expect_idle("t4_end");

    // Direct mode: vector table, one cycle latency from sel
    @(negedge clk);
    in_data = mk_bank(1); mode = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    #1 check("t5_load_rdy", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    sel = dir_tbl[0].sel;
    #1;
    check("t5_enter_busy",  32'(busy), 1);
    check("t5_enter_valid", 32'(out_valid), 0);
    check("t5_enter_rdy",   32'(in_ready), 1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      #1;
      check("t5_out1",  32'(out1), 32'(dir_tbl[i].e1));
      check("t5_out2",  32'(out2), 32'(dir_tbl[i].e2));
      check("t5_valid", 32'(out_valid), 32'(dir_tbl[i].ev));
      check("t5_idx",   32'(out_idx), 32'(dir_tbl[i].sel));
      check("t5_last",  32'(out_last), 0);
      if (i < 6) sel = dir_tbl[i + 1].sel;
    end
    // Load and sel together: old bank this cycle, new bank next
    in_data = mk_bank(11); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("t5_old_out1", 32'(out1), 3);
    check("t5_old_out2", 32'(out2), 4);
    @(negedge clk);
    #1;
    check("t5_new_out1", 32'(out1), 13);
    check("t5_new_out2", 32'(out2), 14);
    check("t5_new_valid", 32'(out_valid), 1);
    mode = 1'b0;
    @(negedge clk);
    #1 expect_idle("t5_exit");

    // NPAIRS=3, W=8 instance
    @(negedge clk);
    for (int k = 0; k < 2 * NP2; k++) in_data2[k*W2 +: W2] = W2'(8'hA0 + k);
    in_valid2 = 1'b1; out_ready2 = 1'b1; mode2 = 1'b0;
    for (int p = 0; p < NP2; p++) begin
      @(negedge clk);
      in_valid2 = 1'b0;
      #1;
      check("t6_valid", 32'(out_valid2), 1);
      check("t6_out1",  32'(out1_2), 32'(8'hA0 + 2 * p));
      check("t6_out2",  32'(out2_2), 32'(8'hA1 + 2 * p));
      check("t6_idx",   32'(out_idx2), 32'(p));
      check("t6_last",  32'(out_last2), 32'(p == NP2 - 1));
      check("t6_rdy",   32'(in_ready2), 32'(p == NP2 - 1));
    end
    @(negedge clk);
    #1;
    check("t6_end_valid", 32'(out_valid2), 0);
    check("t6_end_busy",  32'(busy2), 0);

    // Randomized stream against a pair-queue model
    exp_q.delete();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < 2 * NP; k++) rnd[k*W +: W] = W'($urandom);
      in_data = rnd;
      mode    = in_valid ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      exp_valid = (exp_q.size() > 0);
      exp_rdy   = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
      check("rnd_valid", 32'(out_valid), 32'(exp_valid));
      check("rnd_rdy",   32'(in_ready), 32'(exp_rdy));
      if (exp_valid) begin
        check("rnd_out1", 32'(out1), 32'(exp_q[0].a));
        check("rnd_out2", 32'(out2), 32'(exp_q[0].b));
        check("rnd_idx",  32'(out_idx), 32'(exp_q[0].idx));
        check("rnd_last", 32'(out_last), 32'(exp_q[0].last));
      end
      if (exp_valid && out_ready) void'(exp_q.pop_front());
      if (in_valid && exp_rdy) begin
        for (int p = 0; p < NP; p++) begin
          pr.a    = int'(rnd[(2*p)*W +: W]);
          pr.b    = int'(rnd[(2*p+1)*W +: W]);
          pr.idx  = p;
          pr.last = (p == NP - 1);
          exp_q.push_back(pr);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
